menu_nav_ctrl: RTL

MENU_NAV_CTRL -- requirements
Module: menu_nav_ctrl

---
 rtl/menu_nav_ctrl_if.sv | 27 ++
 rtl/menu_nav_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/menu_nav_ctrl_if.sv
// Purpose : bundles the menu button inputs and the menu status outputs into one port.
// Latency : none; wires only.
// Backpressure: none; buttons are levels, menu_exit is a pulse, outputs are free-running.
// Ports   : btn_up/btn_down/btn_enter (levels), menu_exit (pulse) toward the controller;
//           select_text, item_confirm, confirm_idx, menu_active back from it.
interface menu_nav_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_enter;
  logic       menu_exit;
  logic [1:0] select_text;
  logic       item_confirm;
  logic [1:0] confirm_idx;
  logic       menu_active;

  // master: the button/panel side that drives presses and watches the menu
  modport master (
    output btn_up, btn_down, btn_enter, menu_exit,
    input  select_text, item_confirm, confirm_idx, menu_active
  );

  // slave: the navigation controller
  modport slave (
    input  btn_up, btn_down, btn_enter, menu_exit,
    output select_text, item_confirm, confirm_idx, menu_active
  );
endinterface

// File: rtl/menu_nav_ctrl.sv
// Purpose : menu navigation FSM: edge-detects up/down/enter, moves the highlight, confirms a choice.
// Latency : one clk from a button rising edge to the registered output change.
// Backpressure: none; presses arriving outside IDLE are dropped, never queued.
// Ports   : clk, rst_n (async active-low); bus (menu_nav_ctrl_if.slave) carries buttons,
//           menu_exit, select_text, item_confirm, confirm_idx, menu_active.
// Option  : define MENU_NAV_WRAP_EN to wrap the highlight at the ends instead of saturating.
module menu_nav_ctrl #(
  parameter int NUM_ITEMS      = 4,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  menu_nav_ctrl_if.slave   bus
);

  localparam logic [1:0]  LAST_IDX  = 2'(NUM_ITEMS - 1);
  localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] hold_cnt;
  logic        up_q;
  logic        down_q;
  logic        enter_q;
  logic [1:0]  sel;
  logic        confirm;
  logic [1:0]  idx;
  logic        active;

  logic        up_ev;
  logic        down_ev;
  logic        enter_ev;
  logic [1:0]  sel_up;
  logic [1:0]  sel_down;

  // Previous-value flops reset to 1 so a button held through reset gives no edge.
  assign up_ev    = bus.btn_up    & ~up_q;
  assign down_ev  = bus.btn_down  & ~down_q;
  assign enter_ev = bus.btn_enter & ~enter_q;

  // Candidate next highlight for each direction, with end-of-list handling.
  always_comb begin
    sel_up   = sel;
    sel_down = sel;
`ifdef MENU_NAV_WRAP_EN
    sel_up   = (sel == 2'd0)      ? LAST_IDX : sel - 2'd1;
    sel_down = (sel >= LAST_IDX)  ? 2'd0     : sel + 2'd1;
`else
    sel_up   = (sel == 2'd0)      ? sel      : sel - 2'd1;
    sel_down = (sel >= LAST_IDX)  ? sel      : sel + 2'd1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= 16'd0;
      up_q     <= 1'b1;
      down_q   <= 1'b1;
      enter_q  <= 1'b1;
      sel      <= 2'd0;
      confirm  <= 1'b0;
      idx      <= 2'd0;
      active   <= 1'b1;
    end else begin
      // Edge history tracks the buttons in every state, so presses seen
      // while locked are consumed rather than replayed later.
      up_q    <= bus.btn_up;
      down_q  <= bus.btn_down;
      enter_q <= bus.btn_enter;
      confirm <= 1'b0;

      case (state)
        IDLE: begin
          // Enter wins over any simultaneous direction press.
          if (enter_ev) begin
            confirm <= 1'b1;
            idx     <= sel;
            state   <= DONE;
            active  <= 1'b0;
          end else if (up_ev && !down_ev) begin
            sel      <= sel_up;
            hold_cnt <= HOLD_LOAD;
            state    <= LOCK;
            active   <= 1'b0;
          end else if (down_ev && !up_ev) begin
            sel      <= sel_down;
            hold_cnt <= HOLD_LOAD;
            state    <= LOCK;
            active   <= 1'b0;
          end
        end

        LOCK: begin
          // Loaded with HOLDOFF_CYCLES-1 on entry, so LOCK spans HOLDOFF_CYCLES clocks.
          if (hold_cnt == 16'd0) begin
            state  <= IDLE;
            active <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end

        DONE: begin
          if (bus.menu_exit) begin
            hold_cnt <= HOLD_LOAD;
            state    <= LOCK;
          end
        end

        default: begin
          state  <= IDLE;
          active <= 1'b1;
        end
      endcase
    end
  end

  assign bus.select_text  = sel;
  assign bus.item_confirm = confirm;
  assign bus.confirm_idx  = idx;
  assign bus.menu_active  = active;

endmodule
